// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO of {pc, inst, slot_end} beats between fetch and decode.
// Valid/ready on both sides; a synchronous flush empties the queue and drops the
// beat offered in the same cycle. Occupancy count is the sole full/empty indicator.
module if_id_queue #(
    parameter int unsigned          PC_W   = 64,
    parameter int unsigned          INST_W = 32,
    parameter int unsigned          DEPTH  = 4,
    parameter logic [INST_W-1:0]    NOP    = '0,
    localparam int unsigned         CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_slot_end,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_slot_end,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              se_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Handshake decode; in_ready looks only at occupancy, so a full queue refuses
    // a beat even while its head is being popped.
    always_comb begin
        in_ready  = (cnt != FULL);
        out_valid = (cnt != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Pointers and occupancy; flush wins over any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
        end
    end

    // Entry storage: no reset, contents are unobservable while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
            se_mem[wr_ptr]   <= in_slot_end;
        end
    end

    // Head presentation; an empty queue shows a bubble instead of stale storage.
    always_comb begin
        out_pc       = '0;
        out_inst     = NOP;
        out_slot_end = 1'b0;
        if (out_valid) begin
            out_pc       = pc_mem[rd_ptr];
            out_inst     = inst_mem[rd_ptr];
            out_slot_end = se_mem[rd_ptr];
        end
    end

    assign count = cnt;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized stimulus against a queue-based reference model.
module tb_if_id_queue;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam logic [INST_W-1:0] NOP = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              se;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_slot_end;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_slot_end;
    logic [CNT_W-1:0]  count;

    beat_t           mq[$];
    logic [PC_W-1:0] next_pc;
    int              n_cmp = 0;
    int              n_bad = 0;

    if_id_queue #(
        .PC_W  (PC_W),
        .INST_W(INST_W),
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_slot_end (in_slot_end),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_slot_end(out_slot_end),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against what the reference queue says it should be.
    task automatic check_outputs();
        beat_t h;
        h      = '0;
        h.inst = NOP;
        if (mq.size() > 0) h = mq[0];
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        chk("count", 64'(count), 64'(mq.size()));
        chk("out_pc", 64'(out_pc), 64'(h.pc));
        chk("out_inst", 64'(out_inst), 64'(h.inst));
        chk("out_slot_end", 64'(out_slot_end), 64'(h.se));
    endtask

    // One clock: check at negedge, drive new inputs, update model at posedge.
    task automatic cycle(input int in_p, input int out_p, input int fl_p);
        bit do_push;
        bit do_pop;
        beat_t b;
        check_outputs();
        in_valid    = ($urandom_range(99) < in_p);
        out_ready   = ($urandom_range(99) < out_p);
        flush       = ($urandom_range(99) < fl_p);
        in_pc       = next_pc;
        in_inst     = $urandom;
        in_slot_end = $urandom_range(1);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            if (in_valid) next_pc += 4;
        end else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_valid && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                b.pc   = in_pc;
                b.inst = in_inst;
                b.se   = in_slot_end;
                mq.push_back(b);
                next_pc += 4;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle with handshakes active; outputs must clear at once.
    task automatic do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        check_outputs();
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
        flush = 1'b0;
    endtask

    initial begin
        int in_p[7]  = '{90, 10, 100, 70, 100, 50, 60};
        int out_p[7] = '{10, 90, 100, 70, 30, 50, 60};
        int fl_p[7]  = '{0,  0,  0,   5,  3,  10, 2};
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        in_pc       = '0;
        in_inst     = '0;
        in_slot_end = 1'b0;
        next_pc     = 64'h1000;
        @(negedge clk);
        do_reset();
        repeat (5) cycle(0, 50, 0);
        for (int p = 0; p < 7; p++) begin
            repeat (60) cycle(in_p[p], out_p[p], fl_p[p]);
        end
        do_reset();
        for (int p = 6; p >= 0; p--) begin
            repeat (40) cycle(in_p[p], out_p[p], fl_p[p]);
        end
        repeat (8) cycle(0, 100, 0);
        check_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised fetch-to-decode instruction queue: it replaces the single-entry IF/ID register with a DEPTH-entry FIFO of {pc, inst, slot_end} beats. It uses valid/ready handshakes on both sides, so the fetch unit can run ahead of a stalled decoder. A single flush input squashes all buffered and in-flight beats on a branch redirect or exception. It sits between the ifu and the decode stage.

## Interface
- PC_W, 64, program-counter width
- INST_W, 32, instruction width
- DEPTH, 4, number of entries; power of two, at least 2
- NOP, 0, instruction value presented when the queue is empty (bubble)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch beat present
- in_ready  out  1  queue accepts a beat this cycle
- in_pc  in  PC_W  pc of fetched instruction
- in_inst  in  INST_W  fetched instruction
- in_slot_end  in  1  branch-slot-end marker travelling with the beat
- flush  in  1  squash all contents and any beat offered this cycle
- out_valid  out  1  head beat available to decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  PC_W  head pc
- out_inst  out  INST_W  head instruction
- out_slot_end  out  1  head branch-slot-end marker
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry array holding {pc, inst, slot_end}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH by natural overflow.
  - count is the authoritative full/empty indicator.
- push = in_valid & in_ready & ~flush.
  - On push, write entry[wr_ptr] and increment wr_ptr.
- pop = out_valid & out_ready & ~flush.
  - On pop, increment rd_ptr.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Neither: unchanged.
- in_ready = (count != DEPTH).
  - It is combinational from count only; it does not depend on out_ready.
  - A full queue therefore refuses a beat even in a cycle where the head is popped.
- out_valid = (count != 0).
- Output fields:
  - Non-empty: out_pc, out_inst and out_slot_end come combinationally from entry[rd_ptr].
  - Empty: out_pc = 0, out_inst = NOP, out_slot_end = 0.
- flush is synchronous and has priority over everything else.
  - Next state: count = 0, wr_ptr = 0, rd_ptr = 0.
  - The beat offered in the flush cycle is dropped.
  - The head is not considered consumed.
  - Storage contents are left unchanged; they are unobservable once the queue is empty.
- in_ready remains combinational during flush.
  - Upstream may see in_ready = 1 in a flush cycle; the beat is still discarded.
  - The ifu holds responsibility for redirecting its pc.
- Ordering: beats leave in exactly the order accepted, with no duplication or loss except through flush.

## Timing
- Reset (rst_n low, asynchronous assert):
  - count, wr_ptr and rd_ptr are 0 immediately.
  - Outputs become out_valid = 0, in_ready = 1, out_pc = 0, out_inst = NOP, out_slot_end = 0, count = 0.
- Reset deassertion is synchronised externally; the block needs no extra deassertion cycle.
- Reset mid-operation discards all entries and ignores same-cycle handshakes.
- Latency: a beat pushed at edge N is visible on out_* with out_valid = 1 from just after edge N.
  - It can be popped at edge N+1; minimum transit is 1 cycle, with no combinational in-to-out path.
- Throughput: 1 beat per cycle sustained whenever 0 < count < DEPTH and both sides are ready.
- Full boundary (count == DEPTH):
  - in_ready = 0.
  - After a pop at edge N, in_ready = 1 from edge N onward.
- Empty boundary (count == 0):
  - Pop is impossible.
  - A push at edge N gives count = 1 after N.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble and no change in count behaviour.
- Simultaneous flush and reset: reset dominates.

## Test plan
- Reset then idle, DEPTH=4:
  - Drive rst_n=0 while in_valid=1 -> in_ready=1, out_valid=0, out_inst=0, count=0 throughout.
  - After release with in_valid=0 for 5 cycles, the state is unchanged.
- Fill and drain, DEPTH=4, out_ready=0:
  - Push pc 0x1000/0x1004/0x1008/0x100C -> count 1,2,3,4; in_ready=0 after the 4th push.
  - A 5th beat is held by upstream.
  - Then out_ready=1 -> outputs 0x1000..0x100C in order, each with its inst, then out_valid=0 and out_inst=NOP.
- Streaming with wrap:
  - in_valid=out_ready=1 for 20 cycles with pc incrementing by 4 from 0x0 -> count stays 1.
  - Output pc sequence equals input sequence, delayed one cycle, across 5 pointer wraps.
- Full with simultaneous pop:
  - count=4, in_valid=1, out_ready=1 -> the pop occurs, the beat is refused (in_ready=0), and count becomes 3.
  - Next cycle in_ready=1 and the beat is accepted; count stays 3 with push+pop.
- Flush priority:
  - count=3, assert flush with in_valid=out_ready=1 -> next cycle count=0, out_valid=0.
  - The flush-cycle beat never appears at the output; the next pushed pc 0x2000 is the first output.
- slot_end transport:
  - Push beats with in_slot_end = 0,1,0 -> out_slot_end = 0,1,0 aligned to matching pcs.
  - out_slot_end = 0 whenever the queue is empty.
